// File: rtl/axis_stream_checker_if.sv
// axis_stream_checker_if: AXI-Stream beat bundle for the expected and observed checker ports
interface axis_stream_checker_if #(parameter int DATA_WIDTH = 64);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: in-order AXI-S scoreboard sink with counters and first-error capture.
// Define AXIS_CHK_BACKPRESSURE_EN to add bp_thresh and LFSR-throttled mon tready.
module axis_stream_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 32,
  parameter int HALT_ON_ERR = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
`ifdef AXIS_CHK_BACKPRESSURE_EN
  input  logic [7:0] bp_thresh,
`endif
  axis_stream_checker_if.slave exp,
  axis_stream_checker_if.slave mon,
  output logic [CNT_WIDTH-1:0] beats_ok,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic err_sticky,
  output logic [CNT_WIDTH-1:0] first_err_pkt,
  output logic [CNT_WIDTH-1:0] first_err_beat,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic halted,
  output logic empty
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_k [DEPTH];
  logic mem_l [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CNT_WIDTH-1:0] beat_idx;
  logic [DATA_WIDTH-1:0] mask;
  logic full, push, pop, mism, bp_gate;
  function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] v);
    return &v ? v : v + CNT_WIDTH'(1);
  endfunction
  for (genvar b = 0; b < KEEP_WIDTH; b++) begin : g_mask
    assign mask[8*b +: 8] = {8{mem_k[rd_ptr][b]}};
  end
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign halted = state == HALT;
  assign exp.tready = !full && !clear && !rst;
  assign mon.tready = !empty && state == RUN && !clear && bp_gate;
  assign push = exp.tvalid && exp.tready;
  assign pop = mon.tvalid && mon.tready;
  assign mism = (mon.tkeep != mem_k[rd_ptr]) || (mon.tlast != mem_l[rd_ptr]) ||
                |((mon.tdata ^ mem_d[rd_ptr]) & mask);
`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else if (clear) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign bp_gate = lfsr[7:0] >= bp_thresh;
`else
  assign bp_gate = 1'b1;
`endif
  always_ff @(posedge clk)
    if (push) begin
      mem_d[wr_ptr] <= exp.tdata;
      mem_k[wr_ptr] <= exp.tkeep;
      mem_l[wr_ptr] <= exp.tlast;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {beats_ok, err_count, pkt_count, err_sticky, first_err_pkt, first_err_beat} <= '0;
      {first_err_exp, first_err_got, beat_idx, wr_ptr, rd_ptr, count} <= '0;
      state <= RUN;
    end else if (clear) begin
      {beats_ok, err_count, pkt_count, err_sticky, first_err_pkt, first_err_beat} <= '0;
      {first_err_exp, first_err_got, beat_idx, wr_ptr, rd_ptr, count} <= '0;
      state <= RUN;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        pkt_count <= mon.tlast ? sat(pkt_count) : pkt_count;
        beat_idx <= mon.tlast ? '0 : sat(beat_idx);
        if (mism) begin
          err_count <= sat(err_count);
          err_sticky <= 1'b1;
          if (HALT_ON_ERR != 0) state <= HALT;
          if (!err_sticky) begin
            first_err_pkt <= pkt_count;
            first_err_beat <= beat_idx;
            first_err_exp <= mem_d[rd_ptr];
            first_err_got <= mon.tdata;
          end
        end else begin
          beats_ok <= sat(beats_ok);
        end
      end
    end
endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: directed stimulus against a queue-based scoreboard model of the checker
module tb_axis_stream_checker;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int CW = 32;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  logic clk = 0, rst = 1, clear = 0;
  logic [CW-1:0] beats_ok, err_count, pkt_count, first_err_pkt, first_err_beat;
  logic [DW-1:0] first_err_exp, first_err_got;
  logic err_sticky, halted, empty;
  int checks = 0, failures = 0;
  beat_t q[$];
  int m_ok, m_err, m_pkt, m_beat, m_fpkt, m_fbeat;
  logic [63:0] m_fexp, m_fgot;
  bit m_sticky, m_halt;
  axis_stream_checker_if #(.DATA_WIDTH(DW)) e_if();
  axis_stream_checker_if #(.DATA_WIDTH(DW)) m_if();
  axis_stream_checker dut (
    .clk(clk), .rst(rst), .clear(clear),
`ifdef AXIS_CHK_BACKPRESSURE_EN
    .bp_thresh(8'h00),
`endif
    .exp(e_if), .mon(m_if),
    .beats_ok(beats_ok), .err_count(err_count), .pkt_count(pkt_count),
    .err_sticky(err_sticky), .first_err_pkt(first_err_pkt), .first_err_beat(first_err_beat),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .halted(halted), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, g, x, $time);
    end
  endtask
  function automatic bit differs(input beat_t e, input logic [63:0] d, input logic [7:0] k, input logic l);
    if (k != e.k || l != e.l) return 1;
    for (int i = 0; i < 8; i++)
      if (e.k[i] && d[8*i +: 8] != e.d[8*i +: 8]) return 1;
    return 0;
  endfunction
  function automatic bit m_er();
    return !clear && q.size() < DEPTH;
  endfunction
  function automatic bit m_mr();
    return !clear && q.size() > 0 && !m_halt;
  endfunction
  // Compare current outputs, then advance the model across the coming rising edge
  always @(negedge clk) begin
    beat_t e;
    bit er, mr;
    if (!rst) begin
      chk("exp_tready", e_if.tready, m_er());
      chk("mon_tready", m_if.tready, m_mr());
      chk("beats_ok", beats_ok, m_ok);
      chk("err_count", err_count, m_err);
      chk("pkt_count", pkt_count, m_pkt);
      chk("err_sticky", err_sticky, m_sticky);
      chk("first_err_pkt", first_err_pkt, m_fpkt);
      chk("first_err_beat", first_err_beat, m_fbeat);
      chk("first_err_exp", first_err_exp, m_fexp);
      chk("first_err_got", first_err_got, m_fgot);
      chk("halted", halted, m_halt);
      chk("empty", empty, q.size() == 0);
    end
    if (rst || clear) begin
      q.delete();
      {m_ok, m_err, m_pkt, m_beat, m_fpkt, m_fbeat} = '0;
      {m_fexp, m_fgot, m_sticky, m_halt} = '0;
    end else begin
      er = m_er();
      mr = m_mr();
      if (mr && m_if.tvalid) begin
        e = q.pop_front();
        if (differs(e, m_if.tdata, m_if.tkeep, m_if.tlast)) begin
          if (!m_sticky) begin
            m_fpkt = m_pkt;
            m_fbeat = m_beat;
            m_fexp = e.d;
            m_fgot = m_if.tdata;
          end
          m_err++;
          m_sticky = 1;
          m_halt = 1;
        end else m_ok++;
        if (m_if.tlast) begin
          m_pkt++;
          m_beat = 0;
        end else m_beat++;
      end
      if (er && e_if.tvalid) q.push_back('{e_if.tdata, e_if.tkeep, e_if.tlast});
    end
  end
  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit r = 0;
    int n = 0;
    e_if.tdata = d; e_if.tkeep = k; e_if.tlast = l; e_if.tvalid = 1;
    do begin
      @(negedge clk) r = e_if.tready;
      @(posedge clk) n++;
    end while (!r && n < 200);
    #1 e_if.tvalid = 0;
    if (!r) begin
      checks++; failures++;
      $display("FAIL push_timeout got=no_ready expected=ready data=%0h", d);
    end
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit r = 0;
    int n = 0;
    m_if.tdata = d; m_if.tkeep = k; m_if.tlast = l; m_if.tvalid = 1;
    do begin
      @(negedge clk) r = m_if.tready;
      @(posedge clk) n++;
    end while (!r && n < 200);
    #1 m_if.tvalid = 0;
    if (!r) begin
      checks++; failures++;
      $display("FAIL send_timeout got=no_ready expected=ready data=%0h", d);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    clear = 1;
    idle(1);
    clear = 0;
  endtask
  task automatic at_check();
    idle(2);
    @(negedge clk);
    #1;
  endtask
  task automatic back();
    @(posedge clk);
    #1;
  endtask
  initial begin
    e_if.tvalid = 0; e_if.tdata = 0; e_if.tkeep = 0; e_if.tlast = 0;
    m_if.tvalid = 0; m_if.tdata = 0; m_if.tkeep = 0; m_if.tlast = 0;
    idle(2);
    rst = 0;
    at_check();
    chk("rst_beats_ok", beats_ok, 0);
    chk("rst_empty", empty, 1);
    chk("rst_mon_tready", m_if.tready, 0);
    chk("rst_exp_tready", e_if.tready, 1);
    back();
    push(64'h1111111111111111, 8'hFF, 0);
    push(64'h2222222222222222, 8'hFF, 0);
    push(64'h3333333333333333, 8'hFF, 1);
    send(64'h1111111111111111, 8'hFF, 0);
    send(64'h2222222222222222, 8'hFF, 0);
    send(64'h3333333333333333, 8'hFF, 1);
    at_check();
    chk("match_beats_ok", beats_ok, 3);
    chk("match_pkt", pkt_count, 1);
    chk("match_sticky", err_sticky, 0);
    chk("match_empty", empty, 1);
    chk("model_ok", m_ok, 3);
    back();
    clr();
    push(64'hAAAAAAAA12345678, 8'h0F, 1);
    send(64'hBBBBBBBB12345678, 8'h0F, 1);
    at_check();
    chk("mask_beats_ok", beats_ok, 1);
    chk("mask_err", err_count, 0);
    back();
    clr();
    push(64'h1, 8'hFF, 1);
    push(64'h4, 8'hFF, 0);
    push(64'h5, 8'hFF, 1);
    push(64'h7, 8'hFF, 1);
    send(64'h1, 8'hFF, 1);
    send(64'h4, 8'hFF, 0);
    send(64'h6, 8'hFF, 1);
    at_check();
    chk("mm_err", err_count, 1);
    chk("mm_beats_ok", beats_ok, 2);
    chk("mm_fpkt", first_err_pkt, 1);
    chk("mm_fbeat", first_err_beat, 1);
    chk("mm_fexp", first_err_exp, 64'h5);
    chk("mm_fgot", first_err_got, 64'h6);
    chk("mm_halted", halted, 1);
    chk("mm_mon_tready", m_if.tready, 0);
    chk("mm_empty", empty, 0);
    chk("model_fgot", m_fgot, 64'h6);
    back();
    clr();
    at_check();
    chk("clr_halted", halted, 0);
    chk("clr_err", err_count, 0);
    chk("clr_beats_ok", beats_ok, 0);
    chk("clr_empty", empty, 1);
    back();
    push(64'hAB, 8'hFF, 1);
    send(64'hAB, 8'h7F, 1);
    at_check();
    chk("keep_err", err_count, 1);
    chk("keep_pkt", pkt_count, 1);
    chk("keep_fpkt", first_err_pkt, 0);
    back();
    clr();
    push(64'hCD, 8'hFF, 1);
    send(64'hCD, 8'hFF, 0);
    at_check();
    chk("last_err", err_count, 1);
    chk("last_pkt", pkt_count, 0);
    back();
    clr();
    for (int i = 0; i < DEPTH; i++) push(64'(i), 8'hFF, i % 4 == 3);
    at_check();
    chk("full_exp_tready", e_if.tready, 0);
    back();
    fork
      for (int i = DEPTH; i < 4 * DEPTH; i++) push(64'(i), 8'hFF, i % 4 == 3);
      for (int j = 0; j < 4 * DEPTH; j++) send(64'(j), 8'hFF, j % 4 == 3);
    join
    at_check();
    chk("wrap_beats_ok", beats_ok, 4 * DEPTH);
    chk("wrap_err", err_count, 0);
    chk("wrap_pkt", pkt_count, DEPTH);
    chk("wrap_empty", empty, 1);
    back();
    clr();
    push(64'h10, 8'hFF, 0);
    push(64'h11, 8'hFF, 1);
    clear = 1;
    e_if.tdata = 64'h12; e_if.tkeep = 8'hFF; e_if.tlast = 1; e_if.tvalid = 1;
    m_if.tdata = 64'h10; m_if.tkeep = 8'hFF; m_if.tlast = 0; m_if.tvalid = 1;
    idle(1);
    clear = 0; e_if.tvalid = 0; m_if.tvalid = 0;
    at_check();
    chk("prio_beats_ok", beats_ok, 0);
    chk("prio_empty", empty, 1);
    chk("prio_exp_tready", e_if.tready, 1);
    back();
    push(64'h20, 8'hFF, 0);
    push(64'h21, 8'hFF, 0);
    push(64'h22, 8'hFF, 1);
    send(64'h20, 8'hFF, 0);
    rst = 1;
    idle(1);
    rst = 0;
    at_check();
    chk("rstmid_beats_ok", beats_ok, 0);
    chk("rstmid_err", err_count, 0);
    chk("rstmid_empty", empty, 1);
    back();
    push(64'h30, 8'hFF, 1);
    send(64'h30, 8'hFF, 1);
    at_check();
    chk("post_beats_ok", beats_ok, 1);
    chk("post_pkt", pkt_count, 1);
    back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
